// File: rtl/regfile_scoreboard.sv
// Integer register file x0-x31 with writeback bypass and per-register
// pending-write counters that stall decode on read-after-write hazards.
module regfile_scoreboard #(
  parameter int              XLEN    = 64,
  parameter int              CNT_W   = 3,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_en_rd,
  output logic            hazard_stall,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            wb_en_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic [XLEN-1:0] a0,
  output logic [XLEN-1:0] a1,
  output logic [XLEN-1:0] a2,
  output logic [XLEN-1:0] a3,
  output logic [XLEN-1:0] a4,
  output logic [XLEN-1:0] a5,
  output logic [XLEN-1:0] a6,
  output logic [XLEN-1:0] a7
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  regs [32];
  logic [CNT_W-1:0] cnt  [32];

  logic        wb_hit;
  logic        inc;
  logic [31:0] hit_r;
  logic [31:0] busy;
  logic        rs1_haz, rs2_haz, rd_full;

  assign wb_hit = wb_valid && wb_en_rd && (wb_rd != 5'd0);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit_r = '0;
    busy  = '0;
    for (int r = 1; r < 32; r++) begin
      hit_r[r] = wb_hit && (wb_rd == 5'(r));
      // A write retiring this cycle is bypassed; saturate so a stray
      // post-flush writeback cannot make an idle register look busy.
      busy[r]  = cnt[r] > {{(CNT_W-1){1'b0}}, hit_r[r]};
    end
  end

  assign rs1_haz = rs1_used && (rs1 != 5'd0) && busy[rs1];
  assign rs2_haz = rs2_used && (rs2 != 5'd0) && busy[rs2];
  assign rd_full = issue_en_rd && (issue_rd != 5'd0) &&
                   (cnt[issue_rd] == CNT_MAX) && !hit_r[issue_rd];

  assign hazard_stall = issue_valid && (rs1_haz || rs2_haz || rd_full);
  assign inc = issue_valid && !hazard_stall && !flush && issue_en_rd && (issue_rd != 5'd0);

  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (rs1 == 5'd0)                    rs1_data = '0;
    else if (wb_hit && (wb_rd == rs1))  rs1_data = wb_result;
    if (rs2 == 5'd0)                    rs2_data = '0;
    else if (wb_hit && (wb_rd == rs2))  rs2_data = wb_result;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the register array is reset explicitly because software relies on x2 = SP_INIT and zeroed GPRs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (wb_hit) regs[wb_rd] <= wb_result;
      for (int i = 1; i < 32; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (inc && (issue_rd == 5'(i)) && !hit_r[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!(inc && (issue_rd == 5'(i))) && hit_r[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign a0 = regs[10];
  assign a1 = regs[11];
  assign a2 = regs[12];
  assign a3 = regs[13];
  assign a4 = regs[14];
  assign a5 = regs[15];
  assign a6 = regs[16];
  assign a7 = regs[17];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic,
// compared every cycle against a behavioural register/count model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, issue_rd, wb_rd;
  logic        rs1_used, rs2_used, issue_valid, issue_en_rd;
  logic        wb_valid, wb_en_rd, flush;
  logic [63:0] wb_result;
  logic [63:0] rs1_data, rs2_data;
  logic        hazard_stall;
  logic [63:0] a0, a1, a2, a3, a4, a5, a6, a7;

  regfile_scoreboard #(.XLEN(64), .CNT_W(3), .SP_INIT(64'h8000)) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_en_rd(issue_en_rd),
    .hazard_stall(hazard_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_en_rd(wb_en_rd), .wb_result(wb_result),
    .flush(flush),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural values and outstanding-write counts.
  logic [63:0] m_regs [32];
  int          m_cnt  [32];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else
      passed++;
  endtask

  function automatic bit m_hit();
    return wb_valid && wb_en_rd && wb_rd != 0;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] r);
    if (r == 0) return 64'h0;
    if (m_hit() && wb_rd == r) return wb_result;
    return m_regs[r];
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    int left;
    left = m_cnt[r] - ((m_hit() && wb_rd == r) ? 1 : 0);
    return left > 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = (rs1_used && rs1 != 0 && m_busy(rs1)) ||
        (rs2_used && rs2 != 0 && m_busy(rs2)) ||
        (issue_en_rd && issue_rd != 0 && m_cnt[issue_rd] == 7 &&
         !(m_hit() && wb_rd == issue_rd));
    return issue_valid && s;
  endfunction

  task automatic idle();
    reset = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_rd = 0; issue_en_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_en_rd = 0; wb_result = 0; flush = 0;
  endtask

  // Let combinational outputs settle, then compare everything against the model.
  task automatic eval();
    logic [63:0] a_dut [8];
    #1;
    if (!reset) begin
      a_dut = '{a0, a1, a2, a3, a4, a5, a6, a7};
      check("rs1_data", rs1_data, m_read(rs1));
      check("rs2_data", rs2_data, m_read(rs2));
      check("hazard_stall", {63'h0, hazard_stall}, {63'h0, m_stall()});
      for (int i = 0; i < 8; i++)
        check($sformatf("a%0d", i), a_dut[i], m_regs[10+i]);
    end
  endtask

  // Clock edge: advance the model with the same inputs the DUT samples.
  task automatic tick();
    bit stall, inc;
    stall = m_stall();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = (i == 2) ? 64'h8000 : 64'h0;
        m_cnt[i]  = 0;
      end
    end else begin
      inc = issue_valid && !stall && !flush && issue_en_rd && issue_rd != 0;
      if (m_hit()) m_regs[wb_rd] = wb_result;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        if (inc) m_cnt[issue_rd]++;
        if (m_hit() && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_issue(input logic [4:0] rd);
    idle(); issue_valid = 1; issue_en_rd = 1; issue_rd = rd; eval(); tick();
  endtask

  task automatic read1(input logic [4:0] r);
    idle(); issue_valid = 1; rs1 = r; rs1_used = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    reset = 0;

    // Reset state
    rs1 = 2; eval();
    check("reset_sp", rs1_data, 64'h8000);
    check("reset_a0", a0, 64'h0);
    check("reset_stall", {63'h0, hazard_stall}, 64'h0);
    tick();

    // RAW hazard on x5 resolved by same-cycle writeback bypass
    do_issue(5);
    idle(); eval(); tick();
    idle(); eval(); tick();
    read1(5); eval();
    check("raw_x5_stall", {63'h0, hazard_stall}, 64'h1);
    tick();
    read1(5); wb_valid = 1; wb_en_rd = 1; wb_rd = 5; wb_result = 64'hDEAD; eval();
    check("raw_x5_bypass_stall", {63'h0, hazard_stall}, 64'h0);
    check("raw_x5_bypass_data", rs1_data, 64'hDEAD);
    tick();
    read1(5); eval();
    check("x5_cleared", {63'h0, hazard_stall}, 64'h0);
    tick();

    // Two outstanding writes to x7
    do_issue(7);
    do_issue(7);
    idle(); wb_valid = 1; wb_en_rd = 1; wb_rd = 7; wb_result = 64'h7; eval(); tick();
    read1(7); eval();
    check("x7_still_busy", {63'h0, hazard_stall}, 64'h1);
    tick();
    read1(7); wb_valid = 1; wb_en_rd = 1; wb_rd = 7; wb_result = 64'h77; eval();
    check("x7_last_wb", {63'h0, hazard_stall}, 64'h0);
    tick();

    // x0 is inert
    read1(0); issue_en_rd = 1; issue_rd = 0;
    wb_valid = 1; wb_en_rd = 1; wb_rd = 0; wb_result = 64'h1; eval();
    check("x0_read", rs1_data, 64'h0);
    check("x0_stall", {63'h0, hazard_stall}, 64'h0);
    tick();
    read1(0); eval();
    check("x0_after", rs1_data, 64'h0);
    tick();

    // Same-cycle issue and writeback on x9 leaves count at 1
    do_issue(9);
    idle(); issue_valid = 1; issue_en_rd = 1; issue_rd = 9;
    wb_valid = 1; wb_en_rd = 1; wb_rd = 9; wb_result = 64'h9; eval(); tick();
    read1(9); eval();
    check("x9_busy", {63'h0, hazard_stall}, 64'h1);
    tick();

    // Flush with simultaneous writeback to x10, then no underflow
    do_issue(10); do_issue(10); do_issue(10);
    idle(); flush = 1; wb_valid = 1; wb_en_rd = 1; wb_rd = 10; wb_result = 64'h42; eval(); tick();
    read1(9); eval();
    check("flush_a0", a0, 64'h42);
    check("flush_x9_free", {63'h0, hazard_stall}, 64'h0);
    tick();
    idle(); wb_valid = 1; wb_en_rd = 1; wb_rd = 10; wb_result = 64'h43; eval(); tick();
    read1(10); eval();
    check("no_underflow", {63'h0, hazard_stall}, 64'h0);
    check("a0_updated", a0, 64'h43);
    tick();

    // Counter saturation on x3
    for (int i = 0; i < 7; i++) do_issue(3);
    idle(); issue_valid = 1; issue_en_rd = 1; issue_rd = 3; eval();
    check("x3_full_stall", {63'h0, hazard_stall}, 64'h1);
    tick();
    idle(); issue_valid = 1; issue_en_rd = 1; issue_rd = 3; eval();
    check("x3_count_held", {63'h0, hazard_stall}, 64'h1);
    tick();
    idle(); issue_valid = 0; issue_en_rd = 1; issue_rd = 3; eval();
    check("no_issue_no_stall", {63'h0, hazard_stall}, 64'h0);
    tick();
    idle(); flush = 1; eval(); tick();

    // Random traffic over a narrow register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset       = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      rs1         = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5) + 9);
      rs2         = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5) + 9);
      rs1_used    = 1'($urandom_range(0, 1));
      rs2_used    = 1'($urandom_range(0, 1));
      issue_valid = 1'($urandom_range(0, 3) != 0);
      issue_en_rd = 1'($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(0, 5) + 9);
      wb_valid    = 1'($urandom_range(0, 2) != 0);
      wb_en_rd    = 1'($urandom_range(0, 4) != 0);
      wb_rd       = 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(0, 5) + 9);
      wb_result   = {32'($urandom), 32'($urandom)};
      eval();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
